mem_responder: RTL and testbench

- Memory-side responder for the processor memory handshake. The instruction-fetch and execute FSMs drive mem_EN, mem_RW, the MAR address and MDR write data; this block answers them.
- It holds a word-addressed RAM, models a configurable access latency and returns read data with MFC (memory function complete).
- It sits between MAR/MDR and the datapath's MFC input, so fetch and load/store sequencing can be simulated end to end.

---
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM that answers the mem_EN/mem_RW/MFC handshake with a fixed
// access latency and a four-phase completion handshake.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_EN,
  input  logic              mem_RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              MFC,
  output logic              busy
);

  localparam int         DEPTH    = 2**ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mfc;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_capture;
  logic              w_access;
  logic              w_acc_rw;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_we;

  // With LATENCY=1 the access happens on the capture edge, so operands come
  // straight from the inputs; otherwise from the latched copies.
  always_comb begin
    w_capture = (r_state == S_IDLE) && mem_EN;
    if (w_capture) begin
      w_acc_rw    = mem_RW;
      w_acc_addr  = addr;
      w_acc_wdata = wdata;
      w_access    = (LATENCY == 1);
    end else begin
      w_acc_rw    = r_rw;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_access    = (r_state == S_WAIT) && (r_cnt == 4'd1);
    end
    w_we = w_access && !w_acc_rw;
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_acc_addr] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mfc   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (w_access && w_acc_rw) begin
        r_rdata <= r_mem[w_acc_addr];
      end
      case (r_state)
        S_IDLE: begin
          if (mem_EN) begin
            r_rw    <= mem_RW;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= S_DONE;
              r_mfc   <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        // Completion is not gated by mem_EN, so an aborted access still pulses MFC.
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_access) begin
            r_state <= S_DONE;
            r_mfc   <= 1'b1;
          end
        end
        S_DONE: begin
          if (!mem_EN) begin
            r_state <= S_IDLE;
            r_mfc   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mfc   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign MFC   = r_mfc;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a handshake-level reference model
// (LATENCY=3 main instance plus a LATENCY=1 instance).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_EN, mem_RW;
  logic [7:0]  addr;
  logic [15:0] wdata, rdata;
  logic        MFC, busy;
  logic        en1, rw1;
  logic [7:0]  addr1;
  logic [15:0] wdata1, rdata1;
  logic        mfc1, busy1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] ref_mem [int];
  int          waddrs [$];
  logic [15:0] exp_rdata;
  logic        busy1_q = 1'b0;
  int          busy1_rises = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .mem_EN(mem_EN), .mem_RW(mem_RW), .addr(addr),
    .wdata(wdata), .rdata(rdata), .MFC(MFC), .busy(busy)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_EN(en1), .mem_RW(rw1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .MFC(mfc1), .busy(busy1)
  );

  always @(negedge clk) begin
    if (busy1 && !busy1_q) busy1_rises <= busy1_rises + 1;
    busy1_q <= busy1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full access on the LATENCY=3 instance; optional input scramble after capture.
  task automatic do_acc(input logic rw, input logic [7:0] a, input logic [15:0] d,
                        input int hold, input bit scr, input logic [7:0] sa,
                        input logic [15:0] sd);
    int n;
    @(negedge clk);
    mem_EN = 1'b1; mem_RW = rw; addr = a; wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk("busy_at_capture", {31'd0, busy}, 32'd1);
        if (scr) begin
          addr = sa; wdata = sd; mem_RW = ~rw;
        end
      end
    end while (!MFC && n < 20);
    chk("latency", n, 32'd3);
    if (rw) begin
      exp_rdata = ref_mem[a];
    end else begin
      if (!ref_mem.exists(a)) waddrs.push_back(int'(a));
      ref_mem[a] = d;
    end
    chk("rdata", {16'd0, rdata}, {16'd0, exp_rdata});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("mfc_hold", {31'd0, MFC}, 32'd1);
    end
    mem_EN = 1'b0; mem_RW = rw;
    @(posedge clk); #1;
    chk("mfc_drop", {31'd0, MFC}, 32'd0);
    chk("busy_drop", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_abort(input logic [7:0] a);
    int n;
    @(negedge clk);
    mem_EN = 1'b1; mem_RW = 1'b1; addr = a;
    @(posedge clk); #1;
    n = 1;
    mem_EN = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    while (!MFC && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_latency", n, 32'd3);
    exp_rdata = ref_mem[a];
    chk("abort_rdata", {16'd0, rdata}, {16'd0, exp_rdata});
    @(posedge clk); #1;
    chk("abort_mfc_pulse", {31'd0, MFC}, 32'd0);
    chk("abort_busy_drop", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    logic [7:0]  ra;
    logic [15:0] rd;
    rst = 1'b0; mem_EN = 1'b0; mem_RW = 1'b0; addr = 8'd0; wdata = 16'd0;
    en1 = 1'b0; rw1 = 1'b0; addr1 = 8'd0; wdata1 = 16'd0;
    exp_rdata = 16'd0;
    #2;
    chk("rst_mfc", {31'd0, MFC}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // write/read at 0x05
    do_acc(1'b0, 8'h05, 16'hBEEF, 1, 1'b0, 8'h00, 16'h0000);
    do_acc(1'b1, 8'h05, 16'h0000, 2, 1'b0, 8'h00, 16'h0000);

    // inputs changed during WAIT must be ignored
    do_acc(1'b0, 8'h11, 16'h0F0F, 0, 1'b0, 8'h00, 16'h0000);
    do_acc(1'b0, 8'h10, 16'h1234, 0, 1'b1, 8'h11, 16'hFFFF);
    do_acc(1'b1, 8'h10, 16'h0000, 0, 1'b0, 8'h00, 16'h0000);
    do_acc(1'b1, 8'h11, 16'h0000, 0, 1'b0, 8'h00, 16'h0000);

    do_abort(8'h05);

    // reset in the middle of a write
    do_acc(1'b0, 8'h20, 16'h1357, 0, 1'b0, 8'h00, 16'h0000);
    do_acc(1'b1, 8'h05, 16'h0000, 0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    mem_EN = 1'b1; mem_RW = 1'b0; addr = 8'h20; wdata = 16'hAAAA;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    exp_rdata = 16'd0;
    chk("rst_async_mfc", {31'd0, MFC}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_rdata", {16'd0, rdata}, 32'd0);
    @(negedge clk); rst = 1'b1; mem_EN = 1'b0;
    do_acc(1'b1, 8'h20, 16'h0000, 0, 1'b0, 8'h00, 16'h0000);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (waddrs.size() == 0 || $urandom_range(0, 1) == 0) begin
        ra = 8'($urandom); rd = 16'($urandom);
        do_acc(1'b0, ra, rd, int'($urandom_range(0, 2)), 1'($urandom),
               8'($urandom), 16'($urandom));
      end else begin
        ra = 8'(waddrs[$urandom_range(0, waddrs.size() - 1)]);
        if ($urandom_range(0, 3) == 0) do_abort(ra);
        else do_acc(1'b1, ra, 16'd0, int'($urandom_range(0, 2)), 1'($urandom),
                    8'($urandom), 16'($urandom));
      end
    end

    // LATENCY=1 instance
    @(negedge clk);
    en1 = 1'b1; rw1 = 1'b0; addr1 = 8'h33; wdata1 = 16'h5A5A;
    @(posedge clk); #1;
    chk("l1_wr_mfc", {31'd0, mfc1}, 32'd1);
    en1 = 1'b0;
    @(posedge clk); #1;
    chk("l1_wr_drop", {31'd0, mfc1}, 32'd0);
    chk("l1_wr_busy", {31'd0, busy1}, 32'd0);
    @(negedge clk); #1;
    base = busy1_rises;
    en1 = 1'b1; rw1 = 1'b1; addr1 = 8'h33; wdata1 = 16'h0000;
    @(posedge clk); #1;
    chk("l1_rd_mfc", {31'd0, mfc1}, 32'd1);
    chk("l1_rd_data", {16'd0, rdata1}, 32'h5A5A);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("l1_hold_mfc", {31'd0, mfc1}, 32'd1);
    end
    en1 = 1'b0;
    @(posedge clk); #1;
    chk("l1_rd_drop", {31'd0, mfc1}, 32'd0);
    @(posedge clk); #1;
    chk("l1_idle_busy", {31'd0, busy1}, 32'd0);
    chk("l1_busy_pulses", busy1_rises - base, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
